// File: rtl/vga_stream_display_if.sv
// vga_stream_display_if: frame-buffer read port plus VGA pin bundle
// Signals:
//   mem_addr, mem_rd_en  read request from the display to the frame buffer
//   mem_data             {R,G,B} 4:4:4 word returned by the frame buffer
//   vga_out_r/g/b        colour pins
//   vga_out_hs/vs        active-low sync pins
// Modports: master = display engine, slave = frame buffer / pin observer.
interface vga_stream_display_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [11:0]       mem_data;
    logic [3:0]        vga_out_r;
    logic [3:0]        vga_out_g;
    logic [3:0]        vga_out_b;
    logic              vga_out_hs;
    logic              vga_out_vs;

    modport master (
        output mem_addr, mem_rd_en,
        input  mem_data,
        output vga_out_r, vga_out_g, vga_out_b, vga_out_hs, vga_out_vs
    );

    modport slave (
        input  mem_addr, mem_rd_en,
        output mem_data,
        input  vga_out_r, vga_out_g, vga_out_b, vga_out_hs, vga_out_vs
    );
endinterface

// File: rtl/vga_stream_display.sv
// vga_stream_display: VGA timing generator streaming a frame buffer to the pins with colour modes
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   display_enable    request to show the frame buffer
//   mode, threshold   colour mode (0 pass, 1 gray, 2 invert, 3 threshold) and mode-3 level
//   bus (master)      frame-buffer read port and VGA colour/sync pins
//   pixel_x, pixel_y  raw horizontal/vertical timing counters
//   frame_start       one-clock pulse at h=0, v=0
//   displaying        high while a frame is shown or being finished
module vga_stream_display #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 display_enable,
    input  logic [1:0]           mode,
    input  logic [3:0]           threshold,
    vga_stream_display_if.master bus,
    output logic [11:0]          pixel_x,
    output logic [11:0]          pixel_y,
    output logic                 frame_start,
    output logic                 displaying
);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, DISPLAY, FINISH} state_t;

    state_t            state_q, state_d;
    logic [11:0]       h_q, h_d, v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_base;
    logic [1:0]        mode_q;
    logic [3:0]        thr_q;
    logic [RD_LAT:0]   hs_dly_q, vs_dly_q;
    logic [RD_LAT-1:0] act_dly_q;
    logic [11:0]       col_q, col_d, pix;
    logic [5:0]        y_sum;
    logic [3:0]        y;
    logic              active, hs_raw, vs_raw, rd_en;

    always_comb begin
        h_d         = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
        v_d         = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
        active      = (h_q < H_ACT) && (v_q < V_ACT);
        hs_raw      = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs_raw      = !((v_q >= VS_BEG) && (v_q < VS_END));
        // Gated by rst_n so the pulse stays low while reset is held at the origin.
        frame_start = rst_n && (h_q == 12'd0) && (v_q == 12'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (display_enable) state_d = WAIT_FRAME;
            WAIT_FRAME: if (!display_enable) state_d = IDLE;
                        else if (frame_start) state_d = DISPLAY;
            // Dropping enable exactly at the frame boundary skips the whole next frame.
            DISPLAY:    if (!display_enable) state_d = frame_start ? IDLE : FINISH;
            FINISH:     if (frame_start) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        // Next state is used so the first pixel of a frame is fetched on the entry cycle.
        rd_en     = active && (state_d == DISPLAY || state_d == FINISH);
        addr_base = frame_start ? '0 : addr_q;
        addr_d    = addr_base + ADDR_W'(rd_en);
    end

    always_comb begin
        y_sum = {2'b00, bus.mem_data[11:8]} + {1'b0, bus.mem_data[7:4], 1'b0} + {2'b00, bus.mem_data[3:0]};
        y     = 4'(y_sum >> 2);
        pix   = (mode_q == 2'd0) ? bus.mem_data :
                (mode_q == 2'd1) ? {3{y}} :
                (mode_q == 2'd2) ? ~bus.mem_data :
                {3{(y >= thr_q) ? 4'hF : 4'h0}};
        // act_dly_q's last stage marks the cycle mem_data belongs to a fetched pixel.
        col_d = act_dly_q[RD_LAT-1] ? pix : 12'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            h_q       <= '0;
            v_q       <= '0;
            addr_q    <= '0;
            mode_q    <= '0;
            thr_q     <= '0;
            hs_dly_q  <= '1;
            vs_dly_q  <= '1;
            act_dly_q <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            addr_q    <= addr_d;
            if (frame_start) begin
                mode_q <= mode;
                thr_q  <= threshold;
            end
            hs_dly_q  <= {hs_dly_q[RD_LAT-1:0], hs_raw};
            vs_dly_q  <= {vs_dly_q[RD_LAT-1:0], vs_raw};
            act_dly_q <= RD_LAT'({act_dly_q, rd_en});
            col_q     <= col_d;
        end
    end

    assign bus.mem_addr   = addr_base;
    assign bus.mem_rd_en  = rd_en;
    assign bus.vga_out_r  = col_q[11:8];
    assign bus.vga_out_g  = col_q[7:4];
    assign bus.vga_out_b  = col_q[3:0];
    assign bus.vga_out_hs = hs_dly_q[RD_LAT];
    assign bus.vga_out_vs = vs_dly_q[RD_LAT];
    assign pixel_x        = h_q;
    assign pixel_y        = v_q;
    assign displaying     = (state_q == DISPLAY) || (state_q == FINISH);
endmodule

// File: tb/tb_vga_stream_display.sv
// tb_vga_stream_display: directed, table-driven bench for vga_stream_display on an 8x4 test raster
module tb_vga_stream_display;
    localparam int AW = 19;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        display_enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  threshold = 4'd0;
    logic [11:0] pixel_x, pixel_y, pins;
    logic        frame_start, displaying;
    logic [11:0] mem [32];
    int          total = 0, bad = 0;
    int          mh = 0, mv = 0, since = 0;

    typedef struct {
        logic [1:0]  m;
        logic [3:0]  th;
        logic [11:0] w;
        logic [11:0] exp_rgb;
    } vec_t;

    vga_stream_display_if #(.ADDR_W(AW)) bus ();

    vga_stream_display #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .ADDR_W(AW), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .display_enable(display_enable),
        .mode(mode), .threshold(threshold), .bus(bus),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .displaying(displaying)
    );

    always #5 clk = ~clk;

    assign pins = {bus.vga_out_r, bus.vga_out_g, bus.vga_out_b};

    // Frame buffer with one clock of read latency.
    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr[4:0]];

    // Reference raster position: 14 clocks per line, 7 lines per frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh <= 0;
            mv <= 0;
            since <= 0;
        end else begin
            mh <= (mh == 13) ? 0 : mh + 1;
            if (mh == 13) mv <= (mv == 6) ? 0 : mv + 1;
            since <= since + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 200);
        chk("frame_start_timeout", {31'd0, frame_start}, 32'd1);
    endtask

    function automatic logic [11:0] ref_col(input logic [11:0] w, input logic [1:0] m, input logic [3:0] th);
        int yy;
        yy = (int'(w[11:8]) + 2 * int'(w[7:4]) + int'(w[3:0])) / 4;
        case (m)
            2'd0:    ref_col = w;
            2'd1:    ref_col = {3{4'(yy)}};
            2'd2:    ref_col = {4'(15 - int'(w[11:8])), 4'(15 - int'(w[7:4])), 4'(15 - int'(w[3:0]))};
            default: ref_col = (yy >= int'(th)) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic fill_pattern();
        for (int i = 0; i < 32; i++) mem[i] = 12'(i * 113 + 7);
    endtask

    // Walks one full frame starting on its frame_start cycle and checks strobe, address,
    // pins (two clocks behind the address) and displaying; optional input events at given addresses.
    task automatic check_frame(input string nm, input bit on, input logic [1:0] m, input logic [3:0] th,
                               input bit dsp, input int drop_at, input int raise_at, input int m2_at);
        int er, ec, ed, p1, p2, h, v, a;
        bit act;
        logic [11:0] e;
        er = 0; ec = 0; ed = 0; p1 = -1; p2 = -1;
        for (int i = 0; i < 98; i++) begin
            h = i % 14;
            v = i / 14;
            a = v * 8 + h;
            act = on && (h < 8) && (v < 4);
            if (frame_start !== (i == 0)) er++;
            if (bus.mem_rd_en !== act) er++;
            if (act && bus.mem_addr !== AW'(a)) er++;
            e = (p2 >= 0) ? ref_col(mem[p2], m, th) : 12'h000;
            if (pins !== e) ec++;
            if (i > 0 && displaying !== dsp) ed++;
            if (act && a == drop_at) display_enable = 1'b0;
            if (act && a == raise_at) display_enable = 1'b1;
            if (act && a == m2_at) mode = 2'd2;
            p2 = p1;
            p1 = act ? a : -1;
            step();
        end
        chk({nm, "_rd_addr"}, er, 0);
        chk({nm, "_colour"}, ec, 0);
        chk({nm, "_displaying"}, ed, 0);
    endtask

    initial begin
        vec_t vt [5];
        int hs_err, vs_err, px_err, fs_err, oth_err, fs_cnt, fs_a, fs_b, hs_low, vs_low, t, td, n, early;
        bit ehs, evs;

        vt[0] = '{2'd0, 4'd0, 12'h4A2, 12'h4A2};
        vt[1] = '{2'd1, 4'd0, 12'h4A2, 12'h666};
        vt[2] = '{2'd2, 4'd0, 12'h4A2, 12'hB5D};
        vt[3] = '{2'd3, 4'd7, 12'h4A2, 12'h000};
        vt[4] = '{2'd3, 4'd6, 12'h4A2, 12'hFFF};
        fill_pattern();

        // Reset state
        repeat (3) step();
        chk("rst_pixel_x", pixel_x, 0);
        chk("rst_pixel_y", pixel_y, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_displaying", displaying, 0);
        chk("rst_rgb", pins, 0);
        chk("rst_hs", bus.vga_out_hs, 1);
        chk("rst_vs", bus.vga_out_vs, 1);
        rst_n = 1'b1;
        #1;

        // Timing over two frames in IDLE
        hs_err = 0; vs_err = 0; px_err = 0; fs_err = 0; oth_err = 0;
        fs_cnt = 0; fs_a = -1; fs_b = -1; hs_low = 0; vs_low = 0;
        for (int c = 0; c < 196; c++) begin
            t = mv * 14 + mh;
            td = (t + 96) % 98;
            ehs = !(since >= 2 && (td % 14) >= 10 && (td % 14) < 12);
            evs = !(since >= 2 && (td / 14) == 5);
            if (bus.vga_out_hs !== ehs) hs_err++;
            if (bus.vga_out_vs !== evs) vs_err++;
            if (bus.vga_out_hs === 1'b0) hs_low++;
            if (bus.vga_out_vs === 1'b0) vs_low++;
            if (pixel_x !== 12'(mh) || pixel_y !== 12'(mv)) px_err++;
            if (frame_start !== (mh == 0 && mv == 0)) fs_err++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_a < 0) fs_a = c;
                else if (fs_b < 0) fs_b = c;
            end
            if (bus.mem_rd_en !== 1'b0 || displaying !== 1'b0 || pins !== 12'h000) oth_err++;
            step();
        end
        chk("hs_timing", hs_err, 0);
        chk("vs_timing", vs_err, 0);
        chk("hs_low_cycles", hs_low, 28);
        chk("vs_low_cycles", vs_low, 28);
        chk("pixel_xy", px_err, 0);
        chk("frame_start_pos", fs_err, 0);
        chk("frame_start_count", fs_cnt, 2);
        chk("frame_period", fs_b - fs_a, 98);
        chk("idle_quiet", oth_err, 0);

        // Startup: enable at h=3, v=2 waits for the next frame
        n = 0;
        while (!(mh == 3 && mv == 2) && n < 200) begin
            step();
            n++;
        end
        chk("reach_h3_v2", {31'd0, (mh == 3 && mv == 2)}, 1);
        display_enable = 1'b1;
        early = 0;
        n = 0;
        do begin
            step();
            n++;
            if (!frame_start && (bus.mem_rd_en !== 1'b0 || displaying !== 1'b0)) early++;
        end while (!frame_start && n < 200);
        chk("startup_no_early_read", early, 0);
        chk("startup_frame_start", frame_start, 1);
        check_frame("startup", 1'b1, 2'd0, 4'd0, 1'b1, -1, -1, -1);

        // Colour modes from the vector table
        for (int k = 0; k < 5; k++) begin
            mode = vt[k].m;
            threshold = vt[k].th;
            for (int i = 0; i < 32; i++) mem[i] = vt[k].w;
            wait_fs();
            step();
            step();
            chk($sformatf("colour_mode%0d_th%0d", vt[k].m, vt[k].th), pins, vt[k].exp_rgb);
        end

        // Mode change mid-frame takes effect one frame later
        fill_pattern();
        mode = 2'd0;
        threshold = 4'd0;
        wait_fs();
        check_frame("mode_change_frame", 1'b1, 2'd0, 4'd0, 1'b1, -1, -1, 5);
        check_frame("inverted_frame", 1'b1, 2'd2, 4'd0, 1'b1, -1, -1, -1);

        // FINISH: drop enable at addr 10, re-raise at addr 20
        mode = 2'd0;
        check_frame("finish_frame", 1'b1, 2'd0, 4'd0, 1'b1, 10, 20, -1);
        chk("finish_displaying_at_fs", displaying, 1);
        chk("finish_rd_at_fs", bus.mem_rd_en, 0);
        check_frame("black_frame", 1'b0, 2'd0, 4'd0, 1'b0, -1, -1, -1);

        // Asynchronous reset mid-line
        n = 0;
        while (!(mh == 4 && mv == 1) && n < 200) begin
            step();
            n++;
        end
        chk("pre_reset_rd_en", bus.mem_rd_en, 1);
        chk("pre_reset_displaying", displaying, 1);
        display_enable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_pixel_x", pixel_x, 0);
        chk("async_pixel_y", pixel_y, 0);
        chk("async_mem_addr", bus.mem_addr, 0);
        chk("async_rd_en", bus.mem_rd_en, 0);
        chk("async_frame_start", frame_start, 0);
        chk("async_displaying", displaying, 0);
        chk("async_rgb", pins, 0);
        chk("async_hs_vs", {bus.vga_out_hs, bus.vga_out_vs}, 2'b11);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("release_pixel_xy", {pixel_x, pixel_y}, 0);
        check_frame("post_reset_idle", 1'b0, 2'd0, 4'd0, 1'b0, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_stream_display.md
VGA_STREAM_DISPLAY -- requirements
Module: vga_stream_display

Interface
REQ-001 SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48: horizontal timing in pixel clocks.
REQ-002 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33: vertical timing in lines.
REQ-003 SHALL have parameter ADDR_W=19: frame-buffer address width.
REQ-004 SHALL have parameter RD_LAT=1 (legal 1..4): frame-buffer read latency in clocks.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  pixel clock (25 MHz for 640x480)
- rst_n  in  1  reset; one clock, asynchronous, active-low
- display_enable  in  1  request display
- mode  in  2  0 pass, 1 gray, 2 invert, 3 threshold
- threshold  in  4  mode-3 level
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_rd_en  out  1  read strobe
- mem_data  in  12  {R,G,B} 4:4:4, valid RD_LAT clocks after address
- vga_out_r, vga_out_g, vga_out_b  out  4 each  colour
- vga_out_hs, vga_out_vs  out  1 each  active-low syncs
- pixel_x, pixel_y  out  12 each  raw timing counters
- frame_start  out  1  one-clock pulse at h=0, v=0
- displaying  out  1  high in DISPLAY or FINISH

Function
REQ-006 SHALL run h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params); wrap to 0 increments v_cnt 0..V_TOTAL-1, wrapping to 0.
REQ-007 SHALL free-run counters in every state; pixel_x=h_cnt, pixel_y=v_cnt, both unpipelined.
REQ-008 SHALL form raw hs low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vs likewise with V params.
REQ-009 SHALL define active = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
REQ-010 SHALL implement FSM IDLE, WAIT_FRAME, DISPLAY, FINISH.
- IDLE->WAIT_FRAME when display_enable=1.
- WAIT_FRAME->DISPLAY at frame_start.
- WAIT_FRAME->IDLE if display_enable drops.
- DISPLAY->FINISH when display_enable=0.
- FINISH->IDLE at next frame_start; re-asserting enable in FINISH does not abort it.
REQ-011 SHALL assert mem_rd_en = active && state in {DISPLAY, FINISH} (DISPLAY entered this cycle counts).
REQ-012 SHALL generate mem_addr as a running counter, no multiplier: 0 at frame_start, +1 per mem_rd_en cycle, held otherwise; last pixel = H_ACTIVE*V_ACTIVE-1.
REQ-013 SHALL delay hs, vs and gated-active by RD_LAT+1 clocks so they align with registered colour.
REQ-014 SHALL register colour one clock after mem_data is valid; total address-to-pin latency = RD_LAT+1.
REQ-015 SHALL drive colour 0 whenever delayed gated-active=0.
REQ-016 SHALL compute, with Y=(R+2G+B)>>2 using 6-bit intermediate (Y is 4 bits):
- mode 0: RGB unchanged
- mode 1: R=G=B=Y
- mode 2: each channel = 15-c
- mode 3: all channels 15 if Y>=threshold else 0
REQ-017 SHALL sample mode and threshold at frame_start only; mid-frame changes take effect next frame.
REQ-018 SHALL keep sync outputs valid in all states, including IDLE.
REQ-019 SHALL pulse frame_start high for exactly the clock where h_cnt=0, v_cnt=0.

Reset
REQ-020 SHALL on rst_n=0, asynchronously:
- counters 0, mem_addr 0, state IDLE
- colour 0, mem_rd_en 0, frame_start 0, displaying 0
- hs=vs=1, delay lines cleared
REQ-021 SHALL, after reset release mid-frame, restart timing at h=0, v=0; no partial frame is displayed.

Verification
Bench parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), RD_LAT=1.
REQ-022 SHALL check timing: hs low exactly at h_cnt 10-11; vs low during v_cnt 5; frame period 98 clocks; frame_start once per frame.
REQ-023 SHALL check startup: enable raised at h=3, v=2 -> mem_rd_en stays 0 until next frame_start; then addresses 0..31 appear, with the first pixel on pins 2 clocks after addr 0.
REQ-024 SHALL check colour modes: memory word 0x4A2 ->
- mode 0: pins 4,A,2
- mode 1: Y=6, pins 6,6,6
- mode 2: pins B,5,D
- mode 3, threshold 7: pins 0,0,0
- mode 3, threshold 6: pins F,F,F
REQ-025 SHALL check FINISH: enable dropped at addr 10 -> frame completes through addr 31; next frame all black with mem_rd_en=0; displaying falls at frame_start.
REQ-026 SHALL check mid-frame mode change: 0->2 at addr 5 -> rest of frame in mode 0; next frame inverted.
REQ-027 SHALL check asynchronous reset: rst_n pulsed low mid-line -> all REQ-020 values immediately; after release, counters start at 0 and the FSM is IDLE.
